// File: rtl/cacc.sv
// Complex accumulator: sums LEN signed products per frame into ACC_W-bit real/imag totals.
// Define CACC_SAT_EN to saturate additions and raise a sticky overflow flag (default: wrap, ovf=0).
module cacc #(
    parameter int WIDTH = 8,
    parameter int ACC_W = 12,
    parameter int LEN   = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic                    start,
    input  logic                    in_valid,
    input  logic signed [WIDTH-1:0] mulr,
    input  logic signed [WIDTH-1:0] muli,
    output logic signed [ACC_W-1:0] accr,
    output logic signed [ACC_W-1:0] acci,
    output logic                    out_valid,
    output logic                    busy,
    output logic                    ovf
);

    localparam int CNT_W = $clog2(LEN + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LEN - 1);

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    state_t                   state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic signed [ACC_W-1:0]  accr_q, accr_d;
    logic signed [ACC_W-1:0]  acci_q, acci_d;
    logic                     out_valid_q, out_valid_d;
    logic                     ovf_q, ovf_d;
    logic [ACC_W:0]           sum_r, sum_i;

    // Returns {overflow, sum}; overflow can only be set when saturation is built in.
    function automatic logic [ACC_W:0] acc_add(input logic signed [ACC_W-1:0] a,
                                               input logic signed [ACC_W-1:0] b);
`ifdef CACC_SAT_EN
        logic [ACC_W:0] s;
        s = {a[ACC_W-1], a} + {b[ACC_W-1], b};
        if (s[ACC_W] != s[ACC_W-1]) begin
            if (s[ACC_W])
                return {1'b1, 1'b1, {(ACC_W-1){1'b0}}};
            else
                return {1'b1, 1'b0, {(ACC_W-1){1'b1}}};
        end
        return {1'b0, s[ACC_W-1:0]};
`else
        return {1'b0, a + b};
`endif
    endfunction

    assign sum_r = acc_add(accr_q, ACC_W'(mulr));
    assign sum_i = acc_add(acci_q, ACC_W'(muli));

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        accr_d      = accr_q;
        acci_d      = acci_q;
        ovf_d       = ovf_q;
        out_valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = ACCUM;
                    cnt_d   = '0;
                    accr_d  = '0;
                    acci_d  = '0;
                    ovf_d   = 1'b0;
                end
            end
            ACCUM: begin
                // A restart wins over the sample presented in the same cycle.
                if (start) begin
                    cnt_d  = '0;
                    accr_d = '0;
                    acci_d = '0;
                    ovf_d  = 1'b0;
                end else if (in_valid) begin
                    accr_d = sum_r[ACC_W-1:0];
                    acci_d = sum_i[ACC_W-1:0];
                    ovf_d  = ovf_q | sum_r[ACC_W] | sum_i[ACC_W];
                    cnt_d  = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_CNT) begin
                        state_d     = DONE;
                        out_valid_d = 1'b1;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            accr_q      <= '0;
            acci_q      <= '0;
            out_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
        end else if (enable) begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            accr_q      <= accr_d;
            acci_q      <= acci_d;
            out_valid_q <= out_valid_d;
            ovf_q       <= ovf_d;
        end
    end

    assign accr      = accr_q;
    assign acci      = acci_q;
    assign out_valid = out_valid_q;
    assign busy      = (state_q == ACCUM);
    assign ovf       = ovf_q;

endmodule
